// File: rtl/ascon_cmd_decoder.sv
// Command-stream front end for ascon_core: decodes instruction headers, counts
// data words, and drives the key/bdi handshakes with tail masking and eot/eoi.
module ascon_cmd_decoder #(
    parameter int CCW  = 32,
    parameter int CCSW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [CCSW-1:0] key,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [CCW-1:0]  bdi,
    output logic            bdi_valid,
    input  logic            bdi_ready,
    output logic [3:0]      bdi_type,
    output logic            bdi_eot,
    output logic            bdi_eoi,
    output logic            decrypt_in,
    output logic            hash_in,
    output logic            busy,
    output logic            err
);

    localparam logic [3:0] OP_ENC      = 4'h0;
    localparam logic [3:0] OP_DEC      = 4'h1;
    localparam logic [3:0] OP_HASH     = 4'h2;
    localparam logic [3:0] OP_LD_KEY   = 4'h3;
    localparam logic [3:0] OP_LD_NONCE = 4'h4;
    localparam logic [3:0] OP_LD_AD    = 4'h5;
    localparam logic [3:0] OP_LD_MSG   = 4'h6;
    localparam logic [3:0] OP_LD_TAG   = 4'h7;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_MSG   = 4'h3;
    localparam logic [3:0] D_TAG   = 4'h4;

    typedef enum logic [1:0] {IDLE, DATA, SKIP} state_t;

    state_t      state;
    logic [22:0] cnt;
    logic [3:0]  op_r;
    logic        flag0_r;
    logic [1:0]  len_lo;
    logic        len_zero;

    logic [24:0] nw_sum;
    logic [22:0] nw;
    logic        last;
    logic        key_op;
    logic        rel;
    logic        out_full;
    logic        accept;
    logic [31:0] mask;
    logic [3:0]  op_type;

    always_comb begin
        nw_sum   = {1'b0, s_data[23:0]} + 25'd3;
        nw       = (nw_sum[24:2] == 23'd0) ? 23'd1 : nw_sum[24:2];
        last     = (cnt == 23'd1);
        key_op   = (op_r == OP_LD_KEY);
        rel      = (key_valid && key_ready) || (bdi_valid && bdi_ready);
        out_full = key_valid || bdi_valid;
        // Refill waits on whichever interface is actually holding a word, so a
        // word left over from the previous instruction is never overwritten.
        s_ready  = !rst && (state != DATA || !out_full || rel);
        accept   = s_valid && s_ready;
        busy     = (state != IDLE) || out_full;

        mask = '1;
        if (last) begin
            unique case (len_lo)
                2'd1:    mask = 32'hFF00_0000;
                2'd2:    mask = 32'hFFFF_0000;
                2'd3:    mask = 32'hFFFF_FF00;
                default: mask = '1;
            endcase
        end

        unique case (op_r)
            OP_LD_NONCE: op_type = D_NONCE;
            OP_LD_AD:    op_type = D_AD;
            OP_LD_MSG:   op_type = D_MSG;
            OP_LD_TAG:   op_type = D_TAG;
            default:     op_type = D_NULL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_r       <= OP_ENC;
            flag0_r    <= 1'b0;
            len_lo     <= '0;
            len_zero   <= 1'b0;
            key        <= '0;
            key_valid  <= 1'b0;
            bdi        <= '0;
            bdi_valid  <= 1'b0;
            bdi_type   <= D_NULL;
            bdi_eot    <= 1'b0;
            bdi_eoi    <= 1'b0;
            decrypt_in <= 1'b0;
            hash_in    <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Release first; a same-cycle refill below overrides it.
            if (rel) begin
                key       <= '0;
                key_valid <= 1'b0;
                bdi       <= '0;
                bdi_valid <= 1'b0;
                bdi_type  <= D_NULL;
                bdi_eot   <= 1'b0;
                bdi_eoi   <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (s_data[31:28])
                            OP_ENC:  begin decrypt_in <= 1'b0; hash_in <= 1'b0; end
                            OP_DEC:  begin decrypt_in <= 1'b1; hash_in <= 1'b0; end
                            OP_HASH: begin decrypt_in <= 1'b0; hash_in <= 1'b1; end
                            OP_LD_KEY, OP_LD_NONCE, OP_LD_AD, OP_LD_MSG, OP_LD_TAG: begin
                                op_r     <= s_data[31:28];
                                flag0_r  <= s_data[24];
                                len_lo   <= s_data[1:0];
                                len_zero <= (s_data[23:0] == 24'd0);
                                cnt      <= nw;
                                state    <= DATA;
                            end
                            default: begin
                                err   <= 1'b1;
                                cnt   <= nw;
                                state <= SKIP;
                            end
                        endcase
                    end
                end
                DATA: begin
                    if (accept) begin
                        cnt <= cnt - 23'd1;
                        if (key_op) begin
                            key       <= s_data;
                            key_valid <= 1'b1;
                        end else begin
                            bdi_valid <= 1'b1;
                            bdi_eot   <= last;
                            bdi_eoi   <= last && flag0_r;
                            if (len_zero) begin
                                bdi      <= '0;
                                bdi_type <= D_NULL;
                            end else begin
                                bdi      <= s_data & mask;
                                bdi_type <= op_type;
                            end
                        end
                        if (last) state <= IDLE;
                    end
                end
                SKIP: begin
                    if (accept) begin
                        cnt <= cnt - 23'd1;
                        if (last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_cmd_decoder.sv
// Scoreboard bench for ascon_cmd_decoder: stimulus pushes expected beats,
// a negedge monitor pops and compares on every key/bdi handshake.
module tb_ascon_cmd_decoder;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_MSG   = 4'h3;

    typedef struct packed {
        logic        is_key;
        logic [31:0] data;
        logic [3:0]  typ;
        logic        eot;
        logic        eoi;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] key;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic [31:0] bdi;
    logic        bdi_valid;
    logic        bdi_ready = 1'b1;
    logic [3:0]  bdi_type;
    logic        bdi_eot, bdi_eoi, decrypt_in, hash_in, busy, err;

    int    compared = 0;
    int    mismatched = 0;
    beat_t exp_q[$];
    int    rdy_mode = 0;        // 0: ready, 1: toggle 1,0,0,1, 2: never ready
    int    rdy_idx = 0;
    logic  in_data = 1'b0;
    logic  stall_prev = 1'b0;
    beat_t stall_beat;

    ascon_cmd_decoder #(.CCW(32), .CCSW(32)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .key(key), .key_valid(key_valid), .key_ready(key_ready),
        .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
        .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
        .decrypt_in(decrypt_in), .hash_in(hash_in), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                bdi_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
                rdy_idx++;
            end
            2:       bdi_ready = 1'b0;
            default: bdi_ready = 1'b1;
        endcase
    end

    // Monitor: compare each handshake against the scoreboard, plus idle/stall rules.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) chk("unexpected key beat", 32'(exp_q.size()), 32'd1);
                else begin
                    b = exp_q.pop_front();
                    chk("beat is key", 32'(1), 32'(b.is_key));
                    chk("key data", key, b.data);
                end
            end
            if (bdi_valid && bdi_ready) begin
                if (exp_q.size() == 0) chk("unexpected bdi beat", 32'(exp_q.size()), 32'd1);
                else begin
                    b = exp_q.pop_front();
                    chk("beat is bdi", 32'(0), 32'(b.is_key));
                    chk("bdi data", bdi, b.data);
                    chk("bdi type", 32'(bdi_type), 32'(b.typ));
                    chk("bdi eot", 32'(bdi_eot), 32'(b.eot));
                    chk("bdi eoi", 32'(bdi_eoi), 32'(b.eoi));
                end
            end
            if (key_valid && bdi_valid) chk("both valids", 32'(bdi_valid), 32'd0);
            if (!bdi_valid && (bdi !== 32'd0 || bdi_type !== D_NULL))
                chk("bdi idle value", {bdi[27:0], bdi_type}, {28'd0, D_NULL});
            if (!key_valid && key !== 32'd0) chk("key idle value", key, 32'd0);
            if (stall_prev) begin
                chk("stall bdi stable", bdi, stall_beat.data);
                chk("stall sideband stable", {29'd0, bdi_type[0], bdi_eot, bdi_valid},
                    {29'd0, stall_beat.typ[0], stall_beat.eot, 1'b1});
            end
            if (in_data && bdi_valid && !bdi_ready) chk("s_ready while stalled", 32'(s_ready), 32'd0);
            stall_prev = bdi_valid && !bdi_ready;
            stall_beat = '{is_key: 1'b0, data: bdi, typ: bdi_type, eot: bdi_eot, eoi: bdi_eoi};
        end
    end

    task automatic send(input logic [31:0] w);
        int n = 0;
        s_data  = w;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 50) begin
                chk("s_ready timeout", 32'(s_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic expect_beat(input logic k, input logic [31:0] d, input logic [3:0] t,
                               input logic eot, input logic eoi);
        exp_q.push_back('{is_key: k, data: d, typ: t, eot: eot, eoi: eoi});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset s_ready", 32'(s_ready), 32'd0);
        chk("reset valids", {30'd0, key_valid, bdi_valid}, 32'd0);
        chk("reset data", key | bdi, 32'd0);
        chk("reset sideband", {24'd0, bdi_type, bdi_eot, bdi_eoi, decrypt_in, hash_in},
            {24'd0, D_NULL, 4'd0});
        chk("reset busy/err", {30'd0, busy, err}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Key load: 4 beats, never on bdi
        expect_beat(1, 32'h00010203, D_NULL, 0, 0);
        expect_beat(1, 32'h04050607, D_NULL, 0, 0);
        expect_beat(1, 32'h08090A0B, D_NULL, 0, 0);
        expect_beat(1, 32'h0C0D0E0F, D_NULL, 0, 0);
        send(32'h3000_0010);
        send(32'h00010203); send(32'h04050607); send(32'h08090A0B); send(32'h0C0D0E0F);
        drain("key drained");
        chk("busy after key", 32'(busy), 32'd0);

        // AD len=5: second word masked to its first byte
        expect_beat(0, 32'hAABBCCDD, D_AD, 0, 0);
        expect_beat(0, 32'hEE000000, D_AD, 1, 0);
        send(32'h5000_0005);
        send(32'hAABBCCDD); send(32'hEEFF1122);
        drain("ad drained");

        // Empty MSG with flags[0]: D_NULL zero word
        expect_beat(0, 32'h00000000, D_NULL, 1, 1);
        send(32'h6100_0000);
        send(32'hFFFFFFFF);
        drain("empty msg drained");

        // MSG len=12 with back-pressure
        expect_beat(0, 32'h11111111, D_MSG, 0, 0);
        expect_beat(0, 32'h22222222, D_MSG, 0, 0);
        expect_beat(0, 32'h33333333, D_MSG, 1, 0);
        rdy_mode = 1;
        send(32'h6000_000C);
        in_data = 1'b1;
        send(32'h11111111); send(32'h22222222); send(32'h33333333);
        in_data = 1'b0;
        drain("stalled msg drained");
        rdy_mode = 0;
        @(posedge clk);

        // Mode instructions
        send(32'h1000_0000);
        chk("mode dec", {30'd0, decrypt_in, hash_in}, 32'd2);
        send(32'h2000_0000);
        chk("mode hash", {30'd0, decrypt_in, hash_in}, 32'd1);
        send(32'h0000_0000);
        chk("mode enc", {30'd0, decrypt_in, hash_in}, 32'd0);

        // Unknown op skips its words, then nonce loads normally
        send(32'hF000_0008);
        chk("err set", 32'(err), 32'd1);
        send(32'hDEAD0001); send(32'hDEAD0002);
        expect_beat(0, 32'hA0A1A2A3, D_NONCE, 0, 0);
        expect_beat(0, 32'hB0B1B2B3, D_NONCE, 0, 0);
        expect_beat(0, 32'hC0C1C2C3, D_NONCE, 0, 0);
        expect_beat(0, 32'hD0D1D2D3, D_NONCE, 1, 0);
        send(32'h4000_0010);
        send(32'hA0A1A2A3); send(32'hB0B1B2B3); send(32'hC0C1C2C3); send(32'hD0D1D2D3);
        drain("nonce drained");
        chk("err sticky", 32'(err), 32'd1);

        // Reset mid-nonce with the first word held in the register
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(32'h4000_0010);
        send(32'h12345678);
        chk("held before reset", {bdi_valid, bdi}, {1'b1, 32'h12345678});
        rst = 1'b1;
        #1;
        chk("rst s_ready", 32'(s_ready), 32'd0);
        chk("rst valids", {30'd0, key_valid, bdi_valid}, 32'd0);
        chk("rst data", key | bdi, 32'd0);
        chk("rst sideband", {24'd0, bdi_type, bdi_eot, bdi_eoi, decrypt_in, hash_in},
            {24'd0, D_NULL, 4'd0});
        chk("rst busy/err", {30'd0, busy, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("final queue empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: compared %0d", compared);
        $fatal(1);
    end

endmodule
